// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes diff = a - b (mod 2^WIDTH) one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow
// flip-flop. A start/busy/done handshake frames each operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter only needs to reach WIDTH-1, the index of the last bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic aBit;
  logic bBit;
  logic diffBit;
  logic borrowNext;

  // Full-subtractor cell working on the current LSB of both operand shifters.
  always_comb begin
    aBit       = a_q[0];
    bBit       = b_q[0];
    diffBit    = aBit ^ bBit ^ br_q;
    borrowNext = (~aBit & bBit) | (~(aBit ^ bBit) & br_q);
  end

  // Next-state logic: load operands on acceptance, shift one bit per RUN
  // cycle, and publish the result only on the edge that processes the MSB.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {diffBit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = borrowNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d   = {diffBit, res_q[WIDTH-1:1]};
          borrow_d = borrowNext;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake flags follow directly from the state; results come from the
  // held output registers so they stay stable between operations.
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    diff   = diff_q;
    borrow = borrow_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=6: directed cases,
// held-start throughput, mid-run reset and randomized operations against a
// plain-arithmetic reference.
module tb_serial_subtractor;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] prevDiff;
  logic             prevBorrow;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer subtraction; the borrow is a negative result and
  // the difference is the low WIDTH bits of the signed result.
  function automatic logic [WIDTH:0] refSub(input logic [WIDTH-1:0] aIn,
                                            input logic [WIDTH-1:0] bIn);
    int diffVal;
    diffVal = int'(aIn) - int'(bIn);
    return {(diffVal < 0), WIDTH'(diffVal)};
  endfunction

  // One full operation: idle check, one-cycle start, optional operand
  // scrambling after acceptance, busy/done timing and the final result.
  task automatic applyStimulus(input logic [WIDTH-1:0] aIn,
                               input logic [WIDTH-1:0] bIn,
                               input bit scramble);
    logic [WIDTH:0] expected;
    expected = refSub(aIn, bIn);
    @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleDone", 32'(done), 32'd0);
    start = 1'b1;
    a     = aIn;
    b     = bIn;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("runBusy", 32'(busy), 32'd1);
      checkOutput("runDone", 32'(done), 32'd0);
      checkOutput("runDiffHold", 32'(diff), 32'(prevDiff));
      checkOutput("runBorrowHold", 32'(borrow), 32'(prevBorrow));
    end
    @(negedge clk);
    checkOutput("doneBusy", 32'(busy), 32'd0);
    checkOutput("donePulse", 32'(done), 32'd1);
    checkOutput("diff", 32'(diff), 32'(expected[WIDTH-1:0]));
    checkOutput("borrow", 32'(borrow), 32'(expected[WIDTH]));
    prevDiff   = expected[WIDTH-1:0];
    prevBorrow = expected[WIDTH];
  endtask

  // Main sequence of directed and randomized scenarios.
  initial begin
    int count;
    rst_n      = 1'b0;
    start      = 1'b0;
    a          = '0;
    b          = '0;
    prevDiff   = '0;
    prevBorrow = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstDiff", 32'(diff), 32'd0);
    checkOutput("rstBorrow", 32'(borrow), 32'd0);

    $display("[TB] directed cases");
    applyStimulus(6'b000101, 6'b000001, 1'b0);
    applyStimulus(6'b000001, 6'b000101, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idleHoldDiff", 32'(diff), 32'h3c);
      checkOutput("idleHoldDone", 32'(done), 32'd0);
    end
    applyStimulus(6'b111111, 6'b111111, 1'b0);
    applyStimulus(6'b000000, 6'b000001, 1'b0);
    applyStimulus(6'b101101, 6'b000000, 1'b0);
    applyStimulus(6'b000000, 6'b111111, 1'b0);

    // Start held high: one result every WIDTH+2 cycles, and operand changes
    // in the middle of a run must not disturb the result.
    $display("[TB] held start");
    @(negedge clk);
    a     = 6'b001010;
    b     = 6'b000011;
    start = 1'b1;
    for (int p = 0; p < 4; p++) begin
      count = 0;
      do begin
        @(negedge clk);
        count++;
        if (count == 3) begin
          a = WIDTH'($urandom);
          b = WIDTH'($urandom);
        end
        if (count == 6) begin
          a = 6'b001010;
          b = 6'b000011;
        end
      end while (done !== 1'b1 && count < 20);
      checkOutput("heldSpacing", 32'(count), (p == 0) ? 32'(WIDTH + 1) : 32'(WIDTH + 2));
      checkOutput("heldDiff", 32'(diff), 32'h07);
      checkOutput("heldBorrow", 32'(borrow), 32'd0);
    end
    start      = 1'b0;
    prevDiff   = 6'b000111;
    prevBorrow = 1'b0;
    @(negedge clk);

    // Reset in the middle of a run: outputs clear at once, no done follows.
    $display("[TB] mid-run reset");
    @(negedge clk);
    a     = 6'b100000;
    b     = 6'b000001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstDiff", 32'(diff), 32'd0);
    checkOutput("midRstBorrow", 32'(borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("postRstNoDone", 32'(done), 32'd0);
      checkOutput("postRstNoBusy", 32'(busy), 32'd0);
    end
    prevDiff   = '0;
    prevBorrow = 1'b0;
    applyStimulus(6'b100000, 6'b000001, 1'b0);

    // Randomized operations with operand scrambling and random idle gaps.
    $display("[TB] randomized operations");
    for (int n = 0; n < 1000; n++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes diff = a - b modulo 2^WIDTH and reports the final borrow.
- It is the inverse-direction companion of the combinational ripple-carry adder.
- It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop, trading latency for area.
- A start/busy/done handshake lets a controller issue operations and collect results.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a subtraction; sampled at rising clk.
- a  input  WIDTH  minuend; sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: diff and borrow are newly valid.
- diff  output  WIDTH  a - b mod 2^WIDTH.
- borrow  output  1  1 when a < b as unsigned values (final borrow-out).

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, borrow FF and bit counter are cleared.
  - An operation in flight is abandoned; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch a and b into shift registers, clear the borrow FF, set counter=0, go to RUN. busy=1 after E0.
  - start=0: remain in IDLE.
- RUN, at each edge Ek (k=1..WIDTH), process bit i=k-1:
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d is shifted into the result register from the MSB side; the operand registers shift right; the counter increments.
- RUN exit: at edge E(WIDTH), after bit WIDTH-1 is processed:
  - diff <= full result; borrow <= br'.
  - done=1, busy=0, go to DONE.
- Latency: done is high in the cycle that starts exactly WIDTH clocks after the accepting edge.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE with done=0.
- Start handling:
  - start in RUN or DONE is ignored, not queued.
  - The earliest next acceptance is the first IDLE cycle, giving a throughput of one operation per WIDTH+2 cycles.
- Output stability:
  - diff and borrow change only at the RUN exit edge or on reset.
  - They hold the previous result throughout a subsequent operation and while idle.
- Input independence: a and b may change freely after the accepting edge without affecting the result.
- Arithmetic: unsigned modular. diff always equals (a + ~b + 1) mod 2^WIDTH, and borrow equals the inverse of the adder's carry-out for that sum.
- Boundary cases:
  - a == b gives diff=0, borrow=0.
  - b == 0 gives diff=a, borrow=0.
  - a=0, b=all-ones gives diff=1, borrow=1.
- Simultaneous events: reset deasserting at the same edge as start=1 is not an acceptance. The first acceptance is at a later edge with rst_n=1.

Test Plan:
- WIDTH=6, after reset:
  - Before the first start: busy=0, done=0, diff=000000, borrow=0.
  - a=000101, b=000001, one-cycle start -> busy high for 6 cycles, then done pulses 1 cycle with diff=000100, borrow=0.
- a=000001, b=000101 -> diff=111100, borrow=1. diff holds 111100 for 20 idle cycles.
- a=111111, b=111111 -> diff=000000, borrow=0. a=000000, b=000001 -> diff=111111, borrow=1.
- Start held high continuously with a=001010, b=000011:
  - Each result is 000111, borrow=0.
  - done pulses are spaced exactly 8 cycles apart.
  - Changing a/b mid-RUN has no effect on the result.
- rst_n pulsed low at RUN bit 3 of a=100000, b=000001:
  - All outputs go 0 immediately, with no done.
  - A fresh start then gives diff=011111, borrow=0.
- Randomized check, 1000 ops: compare diff and borrow against the modular reference a-b. Check the done/busy timing of each operation.
